uart_tx_fifo: RTL and testbench

Parametrised UART transmitter, the successor to the fixed 8-bit transmitter in the UART block. It adds configurable data width, baud divider, parity and stop-bit count, plus an input FIFO so the producer can queue words while a frame is on the line. Sits between any byte/word producer and the serial `tx` pin. Queued frames go out back-to-back with no idle gap.

---
 rtl/uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Parametrised UART transmitter with an input FIFO. Words pushed
//             while a frame is on the line are queued and sent back-to-back
//             with no idle gap between frames.
//             Frame = start(0), DATA_W data bits LSB first, optional parity
//             bit, STOP_BITS stop bits(1). Each bit lasts CLKS_PER_BIT clocks.
//  Ports    : clk   in  1       rising-edge clock
//             rst   in  1       asynchronous active-high reset
//             x     in  DATA_W  word to queue, sampled on the accept edge
//             start in  1       push request, accepted when ready=1
//             tx    out 1       serial line, idle high, registered
//             ready out 1       FIFO not full
//             busy  out 1       frame in progress
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DATA_W       = 8,   // 5..9
    parameter int CLKS_PER_BIT = 16,  // >= 1
    parameter int PARITY       = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS    = 1,   // 1 or 2
    parameter int FIFO_DEPTH   = 4    // power of two, >= 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] x,
    input  logic              start,
    output logic              tx,
    output logic              ready,
    output logic              busy
);

    // ------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------
    localparam int c_ptr_w  = (FIFO_DEPTH > 1)   ? $clog2(FIFO_DEPTH)   : 1;
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bit_w  = (DATA_W > 1)       ? $clog2(DATA_W)       : 1;

    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_baud_w-1:0] c_baud_one  = c_baud_w'(1);
    localparam logic [c_bit_w-1:0]  c_data_last = c_bit_w'(DATA_W - 1);
    localparam logic [c_bit_w-1:0]  c_stop_last = c_bit_w'(STOP_BITS - 1);
    localparam logic [c_bit_w-1:0]  c_bit_one   = c_bit_w'(1);
    localparam logic [c_ptr_w-1:0]  c_ptr_one   = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0]  c_cnt_full  = c_cnt_w'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    state_t              r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [c_bit_w-1:0]  r_bit;
    logic [DATA_W-1:0]   r_shift;
    logic                r_par;
    logic                r_tx;

    state_t              w_state_nxt;
    logic [c_baud_w-1:0] w_baud_nxt;
    logic [c_bit_w-1:0]  w_bit_nxt;
    logic [DATA_W-1:0]   w_shift_nxt;
    logic                w_par_nxt;
    logic                w_tx_nxt;

    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_baud_end;
    logic [DATA_W-1:0]   w_head;
    logic                w_head_par;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    assign ready   = (r_count != c_cnt_full);
    assign w_empty = (r_count == '0);
    assign w_push  = start & ready;
    assign w_head  = r_mem[r_rd_ptr];

    // Storage has no reset: reset clears the pointers/count, which is
    // enough to discard every queued word.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= x;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Parity of the FIFO head, captured together with the word at pop
    // time so the shift register is free to move during the data bits.
    // ------------------------------------------------------------------
    generate
        if (PARITY == 1) begin : g_par_odd
            assign w_head_par = ~(^w_head);
        end else if (PARITY == 2) begin : g_par_even
            assign w_head_par = ^w_head;
        end else begin : g_par_none
            assign w_head_par = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transmit FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_par   <= w_par_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign w_baud_end = (r_baud == c_baud_last);

    // ------------------------------------------------------------------
    // Transmit FSM: next state and next line value.
    // tx is registered, so each branch that changes bit computes the
    // level of the *next* bit; that level appears on the same edge the
    // state changes, giving exactly CLKS_PER_BIT cycles per bit.
    // The bit counter is reused to count stop bits.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = r_baud;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_par_nxt   = r_par;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_tx_nxt   = 1'b1;
                w_baud_nxt = '0;
                w_bit_nxt  = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                    w_shift_nxt = w_head;
                    w_par_nxt   = w_head_par;
                    w_tx_nxt    = 1'b0;
                end
            end

            ST_START: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = ST_DATA;
                    w_tx_nxt    = r_shift[0];
                end else begin
                    w_baud_nxt = r_baud + c_baud_one;
                end
            end

            ST_DATA: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == c_data_last) begin
                        w_bit_nxt = '0;
                        if (PARITY != 0) begin
                            w_state_nxt = ST_PARITY;
                            w_tx_nxt    = r_par;
                        end else begin
                            w_state_nxt = ST_STOP;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt   = r_bit + c_bit_one;
                        w_shift_nxt = r_shift >> 1;
                        w_tx_nxt    = r_shift[1];
                    end
                end else begin
                    w_baud_nxt = r_baud + c_baud_one;
                end
            end

            ST_PARITY: begin
                if (w_baud_end) begin
                    w_baud_nxt  = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = ST_STOP;
                    w_tx_nxt    = 1'b1;
                end else begin
                    w_baud_nxt = r_baud + c_baud_one;
                end
            end

            ST_STOP: begin
                if (w_baud_end) begin
                    w_baud_nxt = '0;
                    if (r_bit == c_stop_last) begin
                        w_bit_nxt = '0;
                        // Chain straight into the next frame when a word
                        // is waiting, so there is no idle cycle.
                        if (!w_empty) begin
                            w_pop       = 1'b1;
                            w_state_nxt = ST_START;
                            w_shift_nxt = w_head;
                            w_par_nxt   = w_head_par;
                            w_tx_nxt    = 1'b0;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            w_tx_nxt    = 1'b1;
                        end
                    end else begin
                        w_bit_nxt = r_bit + c_bit_one;
                    end
                end else begin
                    w_baud_nxt = r_baud + c_baud_one;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_baud_nxt  = '0;
                w_bit_nxt   = '0;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign tx   = r_tx;
    assign busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Purpose  : Scoreboard bench for uart_tx_fifo. Five instances cover the
//             default frame, even/odd parity, two stop bits and 5-bit data.
//             Expected frames (bit 0 = first bit on the line) are queued when
//             a word is pushed; one receiver process per instance rebuilds
//             frames from tx and compares against the queue.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int c_cpb  = 4;
    localparam int c_ninst = 5;

    typedef struct {
        int          idx;
        logic [15:0] bits;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [c_ninst-1:0]      start_v;
    logic [c_ninst-1:0]      tx_v;
    logic [c_ninst-1:0]      ready_v;
    logic [c_ninst-1:0]      busy_v;
    logic [c_ninst-1:0][7:0] xs;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   busy_total [c_ninst];
    int   rise_total [c_ninst];

    always #5 clk = ~clk;

    // 0: defaults  1: even parity  2: odd parity  3: two stop bits  4: 5-bit data
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(c_cpb), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut0 (
        .clk(clk), .rst(rst), .x(xs[0]), .start(start_v[0]),
        .tx(tx_v[0]), .ready(ready_v[0]), .busy(busy_v[0]));
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(c_cpb), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut1 (
        .clk(clk), .rst(rst), .x(xs[1]), .start(start_v[1]),
        .tx(tx_v[1]), .ready(ready_v[1]), .busy(busy_v[1]));
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(c_cpb), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut2 (
        .clk(clk), .rst(rst), .x(xs[2]), .start(start_v[2]),
        .tx(tx_v[2]), .ready(ready_v[2]), .busy(busy_v[2]));
    uart_tx_fifo #(.DATA_W(8), .CLKS_PER_BIT(c_cpb), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_dut3 (
        .clk(clk), .rst(rst), .x(xs[3]), .start(start_v[3]),
        .tx(tx_v[3]), .ready(ready_v[3]), .busy(busy_v[3]));
    uart_tx_fifo #(.DATA_W(5), .CLKS_PER_BIT(c_cpb), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .x(xs[4][4:0]), .start(start_v[4]),
        .tx(tx_v[4]), .ready(ready_v[4]), .busy(busy_v[4]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic int pending(input int idx);
        int n = 0;
        foreach (exp_q[i]) if (exp_q[i].idx == idx) n++;
        return n;
    endfunction

    // Receiver: frame starts on the first negedge tx is low; every bit must
    // read the same on all c_cpb samples. A reset during a frame discards it.
    task automatic monitor(input int idx, input int nbits);
        logic [15:0] got;
        bit          stable;
        bit          aborted;
        int          found;
        forever begin
            @(negedge clk);
            if (!rst && tx_v[idx] === 1'b0) begin
                got     = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                for (int j = 0; j < nbits; j++) begin
                    for (int c = 0; c < c_cpb; c++) begin
                        if (!(j == 0 && c == 0)) @(negedge clk);
                        if (rst) aborted = 1'b1;
                        if (c == 0) got[j] = tx_v[idx];
                        else if (tx_v[idx] !== got[j]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    found = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (found < 0 && exp_q[i].idx == idx) found = i;
                    if (found < 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_frame[%0d]: got 0x%0h, required no frame", idx, got);
                    end else begin
                        check($sformatf("frame_bits[%0d]", idx), 32'(got), 32'(exp_q[found].bits));
                        check($sformatf("bit_stable[%0d]", idx), 32'(stable), 32'd1);
                        exp_q.delete(found);
                    end
                end
            end
        end
    endtask

    // Cumulative busy cycles and busy rising edges per instance.
    task automatic busy_counter();
        logic [c_ninst-1:0] prev = '0;
        forever begin
            @(posedge clk);
            #3;
            for (int i = 0; i < c_ninst; i++) begin
                if (busy_v[i] === 1'b1) busy_total[i]++;
                if (busy_v[i] === 1'b1 && prev[i] !== 1'b1) rise_total[i]++;
            end
            prev = busy_v;
        end
    endtask

    task automatic push_word(input int idx, input logic [7:0] data, input logic [15:0] bits);
        exp_t e;
        @(negedge clk);
        xs[idx]      = data;
        start_v[idx] = 1'b1;
        e.idx  = idx;
        e.bits = bits;
        exp_q.push_back(e);
        @(negedge clk);
        start_v[idx] = 1'b0;
    endtask

    task automatic wait_done(input int idx, input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (pending(idx) == 0 && busy_v[idx] === 1'b0) break;
        end
        check($sformatf("frames_outstanding[%0d]", idx), 32'(pending(idx)), 32'd0);
        check($sformatf("busy_after_done[%0d]", idx), 32'(busy_v[idx]), 32'd0);
    endtask

    int b0, r0, b1, b2, b3, b4;
    exp_t ev;

    initial begin
        rst     = 1'b1;
        start_v = '0;
        xs      = '0;
        for (int i = 0; i < c_ninst; i++) begin
            busy_total[i] = 0;
            rise_total[i] = 0;
        end
        fork
            monitor(0, 10);
            monitor(1, 11);
            monitor(2, 11);
            monitor(3, 11);
            monitor(4, 7);
            busy_counter();
        join_none

        // ---- Reset state and idle ----
        @(negedge clk);
        check("reset_tx_ready_busy", 32'({tx_v[0], ready_v[0], busy_v[0]}), 32'b110);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_tx_ready_busy", 32'({tx_v[0], ready_v[0], busy_v[0]}), 32'b110);
        end
        check("idle_all_tx", 32'(tx_v), 32'h1f);

        // ---- Single word 0x77: latency and 40-cycle frame ----
        b0 = busy_total[0];
        r0 = rise_total[0];
        @(negedge clk);
        xs[0]      = 8'h77;
        start_v[0] = 1'b1;
        ev.idx = 0; ev.bits = 16'h02EE; exp_q.push_back(ev);
        @(posedge clk); #1;
        check("tx_on_accept_edge", 32'(tx_v[0]), 32'd1);
        check("busy_on_accept_edge", 32'(busy_v[0]), 32'd0);
        @(negedge clk);
        start_v[0] = 1'b0;
        @(posedge clk); #1;
        check("tx_after_pop_edge", 32'(tx_v[0]), 32'd0);
        check("busy_after_pop_edge", 32'(busy_v[0]), 32'd1);
        wait_done(0, 100);
        check("busy_cycles_single", 32'(busy_total[0] - b0), 32'd40);

        // ---- 0x77 then 0x81 pushed mid-data: back-to-back ----
        b0 = busy_total[0];
        r0 = rise_total[0];
        push_word(0, 8'h77, 16'h02EE);
        repeat (14) @(negedge clk);
        push_word(0, 8'h81, 16'h0302);
        wait_done(0, 200);
        check("busy_cycles_b2b", 32'(busy_total[0] - b0), 32'd80);
        check("busy_rises_b2b", 32'(rise_total[0] - r0), 32'd1);

        // ---- start held 6 edges, 0x01..0x06: FIFO fills, 0x06 dropped ----
        b0 = busy_total[0];
        r0 = rise_total[0];
        @(negedge clk);
        start_v[0] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            xs[0] = 8'(i);
            if (i <= 5) begin
                ev.idx  = 0;
                ev.bits = 16'h0200 + 16'(2 * i);
                exp_q.push_back(ev);
            end
            @(posedge clk); #1;
            if (i == 4) check("ready_after_4th", 32'(ready_v[0]), 32'd1);
            if (i >= 5) check($sformatf("ready_after_accept_%0d", i), 32'(ready_v[0]), 32'd0);
            @(negedge clk);
        end
        start_v[0] = 1'b0;
        wait_done(0, 400);
        check("busy_cycles_fill", 32'(busy_total[0] - b0), 32'd200);
        check("busy_rises_fill", 32'(rise_total[0] - r0), 32'd1);

        // ---- Parity, two stop bits, 5-bit data ----
        b1 = busy_total[1];
        b2 = busy_total[2];
        b3 = busy_total[3];
        b4 = busy_total[4];
        push_word(1, 8'h07, 16'h060E);
        push_word(2, 8'h07, 16'h040E);
        push_word(3, 8'h77, 16'h06EE);
        push_word(4, 8'h15, 16'h006A);
        for (int i = 1; i < c_ninst; i++) wait_done(i, 100);
        check("busy_cycles_even", 32'(busy_total[1] - b1), 32'd44);
        check("busy_cycles_odd",  32'(busy_total[2] - b2), 32'd44);
        check("busy_cycles_stop2", 32'(busy_total[3] - b3), 32'd44);
        check("busy_cycles_dw5",  32'(busy_total[4] - b4), 32'd28);

        // ---- Async reset during data bit 3 of a queued burst ----
        @(negedge clk);
        start_v[0] = 1'b1;
        xs[0] = 8'h11;
        @(negedge clk);
        xs[0] = 8'h22;
        @(negedge clk);
        xs[0] = 8'h33;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        check("tx_data_bit3_before_rst", 32'(tx_v[0]), 32'd0);
        check("busy_before_rst", 32'(busy_v[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_async_tx", 32'(tx_v[0]), 32'd1);
        check("rst_async_ready", 32'(ready_v[0]), 32'd1);
        check("rst_async_busy", 32'(busy_v[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        b0 = busy_total[0];
        repeat (60) @(negedge clk);
        check("busy_cycles_after_rst", 32'(busy_total[0] - b0), 32'd0);
        check("tx_idle_after_rst", 32'(tx_v[0]), 32'd1);
        b0 = busy_total[0];
        push_word(0, 8'hA5, 16'h034A);
        wait_done(0, 100);
        check("busy_cycles_post_rst", 32'(busy_total[0] - b0), 32'd40);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
